// File: rtl/proc_bus_checker.sv
// Bus checker: compares the processor bus each clock against a FIFO of expected
// cycles and keeps saturating per-category pass/fail counters plus a first-fail capture.

module proc_bus_checker_satcnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                  cnt_d = '0;
    else if (inc && !(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module proc_bus_checker #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int NUM_CAT    = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int CW        = (NUM_CAT > 1) ? $clog2(NUM_CAT) : 1,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic                         wr_enable,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         enable,
  input  logic                         clear,
  input  logic                         exp_valid,
  output logic                         exp_ready,
  input  logic [ADDR_WIDTH-1:0]        exp_addr,
  input  logic                         exp_we,
  input  logic                         exp_chk_data,
  input  logic [DATA_WIDTH-1:0]        exp_data,
  input  logic [CW-1:0]                exp_cat,
  output logic [NUM_CAT*CNT_WIDTH-1:0] pass_cnt,
  output logic [NUM_CAT*CNT_WIDTH-1:0] fail_cnt,
  output logic [CNT_WIDTH-1:0]         starved_cnt,
  output logic                         first_fail_valid,
  output logic [ADDR_WIDTH-1:0]        first_fail_addr,
  output logic [CW-1:0]                first_fail_cat,
  output logic [LW-1:0]                fifo_level,
  output logic [1:0]                   state
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STARVED = 2'd2} state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic                  chk;
    logic [DATA_WIDTH-1:0] data;
    logic [CW-1:0]         cat;
  } exp_t;

  exp_t            mem_q [DEPTH];
  exp_t            head, wr_ent;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            full, empty, push, pop, match, cat_ok;
  state_e          state_q, state_d;
  logic            ff_valid_q, ff_valid_d;
  logic [ADDR_WIDTH-1:0] ff_addr_q, ff_addr_d;
  logic [CW-1:0]   ff_cat_q, ff_cat_d;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  // A push into a full FIFO is dropped even if the head pops this cycle.
  assign push   = exp_valid && !full;
  assign pop    = enable && !empty;
  assign wr_ent = '{addr: exp_addr, we: exp_we, chk: exp_chk_data, data: exp_data, cat: exp_cat};
  assign head   = mem_q[rptr_q];

  assign match  = (address == head.addr) && (wr_enable == head.we) &&
                  (!(head.we && head.chk) || (wr_data == head.data));
  assign cat_ok = int'(head.cat) < NUM_CAT;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_ent;
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable)    state_d = IDLE;
    else if (empty) state_d = STARVED;
    else            state_d = RUN;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    ff_valid_d = ff_valid_q;
    ff_addr_d  = ff_addr_q;
    ff_cat_d   = ff_cat_q;
    if (clear) begin
      ff_valid_d = 1'b0;
      ff_addr_d  = '0;
      ff_cat_d   = '0;
    end else if (pop && !match && !ff_valid_q) begin
      ff_valid_d = 1'b1;
      ff_addr_d  = address;
      ff_cat_d   = head.cat;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ff_valid_q <= 1'b0;
      ff_addr_q  <= '0;
      ff_cat_q   <= '0;
    end else begin
      ff_valid_q <= ff_valid_d;
      ff_addr_q  <= ff_addr_d;
      ff_cat_q   <= ff_cat_d;
    end
  end

  for (genvar k = 0; k < NUM_CAT; k++) begin : g_cat
    proc_bus_checker_satcnt #(.CNT_WIDTH(CNT_WIDTH)) u_pass (
      .clk(clk), .resetn(resetn), .clr(clear),
      .inc(pop && cat_ok && match && (head.cat == CW'(k))),
      .cnt(pass_cnt[k*CNT_WIDTH +: CNT_WIDTH])
    );
    proc_bus_checker_satcnt #(.CNT_WIDTH(CNT_WIDTH)) u_fail (
      .clk(clk), .resetn(resetn), .clr(clear),
      .inc(pop && cat_ok && !match && (head.cat == CW'(k))),
      .cnt(fail_cnt[k*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  proc_bus_checker_satcnt #(.CNT_WIDTH(CNT_WIDTH)) u_starved (
    .clk(clk), .resetn(resetn), .clr(clear),
    .inc(enable && empty),
    .cnt(starved_cnt)
  );

  assign exp_ready        = !full;
  assign fifo_level       = level_q;
  assign state            = state_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_addr  = ff_addr_q;
  assign first_fail_cat   = ff_cat_q;
endmodule

// File: tb/tb_proc_bus_checker.sv
// Scoreboard bench for proc_bus_checker: a queue-based reference model predicts the
// post-edge outputs each cycle, a monitor compares them against the DUT.
module tb_proc_bus_checker;
  localparam int AW = 16, DW = 8, DEPTH = 16, NC = 4, CNW = 4, CW = 2, LW = 5;
  localparam int SATV = (1 << CNW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, wr_enable, enable, clear, exp_valid, exp_ready;
  logic          exp_we, exp_chk_data, first_fail_valid;
  logic [AW-1:0] address, exp_addr, first_fail_addr;
  logic [DW-1:0] wr_data, exp_data;
  logic [CW-1:0] exp_cat, first_fail_cat;
  logic [NC*CNW-1:0] pass_cnt, fail_cnt;
  logic [CNW-1:0] starved_cnt;
  logic [LW-1:0]  fifo_level;
  logic [1:0]     state;

  proc_bus_checker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CAT(NC),
                     .CNT_WIDTH(CNW)) dut (
    .clk(clk), .resetn(resetn), .address(address), .wr_enable(wr_enable),
    .wr_data(wr_data), .enable(enable), .clear(clear), .exp_valid(exp_valid),
    .exp_ready(exp_ready), .exp_addr(exp_addr), .exp_we(exp_we),
    .exp_chk_data(exp_chk_data), .exp_data(exp_data), .exp_cat(exp_cat),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .starved_cnt(starved_cnt),
    .first_fail_valid(first_fail_valid), .first_fail_addr(first_fail_addr),
    .first_fail_cat(first_fail_cat), .fifo_level(fifo_level), .state(state)
  );

  typedef struct {
    int unsigned addr;
    bit          we;
    bit          chk;
    int unsigned data;
    int unsigned cat;
  } ent_t;

  typedef struct {
    logic [NC*CNW-1:0] pass;
    logic [NC*CNW-1:0] fail;
    logic [CNW-1:0]    starved;
    logic              ffv;
    logic [AW-1:0]     ffa;
    logic [CW-1:0]     ffc;
    logic [LW-1:0]     lvl;
    logic              rdy;
    logic [1:0]        st;
  } snap_t;

  ent_t        mq[$];
  int unsigned m_pass[NC], m_fail[NC], m_starved, m_ffa, m_ffc;
  bit          m_ffv;
  int unsigned m_state;
  snap_t       sb[$];
  int          vectors = 0, miscompares = 0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int unsigned sat(int unsigned x);
    return (x >= SATV) ? SATV : x + 1;
  endfunction

  function automatic void model_zero_results();
    for (int k = 0; k < NC; k++) begin m_pass[k] = 0; m_fail[k] = 0; end
    m_starved = 0; m_ffv = 0; m_ffa = 0; m_ffc = 0;
  endfunction

  function automatic void model_step();
    bit   empty, full, ok;
    ent_t e, n;
    if (!resetn) begin
      mq.delete(); model_zero_results(); m_state = 0;
      return;
    end
    empty = (mq.size() == 0);
    full  = (mq.size() == DEPTH);
    if (enable && !empty) begin
      e  = mq.pop_front();
      ok = (address == e.addr) && (wr_enable == e.we) &&
           (!(e.we && e.chk) || (wr_data == e.data));
      if (e.cat < NC) begin
        if (ok) m_pass[e.cat] = sat(m_pass[e.cat]);
        else    m_fail[e.cat] = sat(m_fail[e.cat]);
      end
      if (!ok && !m_ffv) begin m_ffv = 1; m_ffa = address; m_ffc = e.cat; end
    end
    if (enable && empty) m_starved = sat(m_starved);
    if (exp_valid && !full) begin
      n.addr = exp_addr; n.we = exp_we; n.chk = exp_chk_data;
      n.data = exp_data; n.cat = exp_cat;
      mq.push_back(n);
    end
    if (clear) model_zero_results();
    m_state = !enable ? 0 : (empty ? 2 : 1);
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    for (int k = 0; k < NC; k++) begin
      s.pass[k*CNW +: CNW] = CNW'(m_pass[k]);
      s.fail[k*CNW +: CNW] = CNW'(m_fail[k]);
    end
    s.starved = CNW'(m_starved);
    s.ffv = m_ffv; s.ffa = AW'(m_ffa); s.ffc = CW'(m_ffc);
    s.lvl = LW'(mq.size()); s.rdy = (mq.size() < DEPTH); s.st = 2'(m_state);
    return s;
  endfunction

  // Monitor: one expected snapshot per clock edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pass_cnt", pass_cnt, e.pass);
        check("fail_cnt", fail_cnt, e.fail);
        check("starved_cnt", starved_cnt, e.starved);
        check("first_fail_valid", first_fail_valid, e.ffv);
        check("first_fail_addr", first_fail_addr, e.ffa);
        check("first_fail_cat", first_fail_cat, e.ffc);
        check("fifo_level", fifo_level, e.lvl);
        check("exp_ready", exp_ready, e.rdy);
        check("state", state, e.st);
      end
    end
  end

  task automatic step();
    model_step();
    sb.push_back(model_snap());
    @(negedge clk);
  endtask

  task automatic set_exp(input bit v, input int unsigned a, input bit we, input bit chk,
                         input int unsigned d, input int unsigned c);
    exp_valid = v; exp_addr = AW'(a); exp_we = we; exp_chk_data = chk;
    exp_data = DW'(d); exp_cat = CW'(c);
  endtask

  task automatic set_bus(input int unsigned a, input bit we, input int unsigned d);
    address = AW'(a); wr_enable = we; wr_data = DW'(d);
  endtask

  task automatic bus_follow_head(input int pct_match);
    if (mq.size() > 0 && $urandom_range(0, 99) < pct_match) begin
      set_bus(mq[0].addr, mq[0].we, ($urandom_range(0, 3) == 0) ? $urandom : mq[0].data);
    end else begin
      set_bus($urandom, 1'($urandom), $urandom);
    end
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      enable = ($urandom_range(0, 9) < 8);
      clear  = ($urandom_range(0, 49) == 0);
      set_exp($urandom_range(0, 9) < 6, $urandom, 1'($urandom), 1'($urandom), $urandom,
              $urandom_range(0, NC-1));
      bus_follow_head(70);
      step();
    end
    clear = 0;
  endtask

  initial begin
    resetn = 0; enable = 0; clear = 0;
    set_exp(0, 0, 0, 0, 0, 0); set_bus(0, 0, 0);
    mq.delete(); model_zero_results(); m_state = 0;
    @(negedge clk);
    repeat (3) step();
    resetn = 1;
    step();

    // Reset-vector fetch then starvation
    set_exp(1, 'hfffc, 0, 0, 0, 0); step();
    set_exp(1, 'hfffd, 0, 0, 0, 0); step();
    set_exp(0, 0, 0, 0, 0, 0);
    enable = 1;
    set_bus('hfffc, 0, 0); step();
    set_bus('hfffd, 0, 0); step();
    set_bus('h0000, 0, 0); step(); step();
    enable = 0; step();

    // Mismatch capture, later mismatch must not overwrite it
    set_exp(1, 'h8000, 0, 0, 0, 1); step();
    set_exp(1, 'h8001, 0, 0, 0, 1); step();
    set_exp(0, 0, 0, 0, 0, 0); enable = 1;
    set_bus('h8000, 0, 0); step();
    set_bus('h8005, 0, 0); step();
    enable = 0; set_exp(1, 'h9001, 0, 0, 0, 2); step();
    set_exp(0, 0, 0, 0, 0, 0); enable = 1; set_bus('h9000, 0, 0); step();
    enable = 0; step();

    // Write-data checking
    set_exp(1, 'h0200, 1, 1, 'ha5, 3); step();
    set_exp(0, 0, 0, 0, 0, 0); enable = 1; set_bus('h0200, 1, 'h5a); step();
    enable = 0; set_exp(1, 'h0200, 1, 1, 'ha5, 3); step();
    set_exp(0, 0, 0, 0, 0, 0); enable = 1; set_bus('h0200, 1, 'ha5); step();
    enable = 0; set_exp(1, 'h0200, 1, 0, 'ha5, 3); step();
    set_exp(0, 0, 0, 0, 0, 0); enable = 1; set_bus('h0200, 1, 'h5a); step();
    enable = 0; step();

    // Fill to full, drop the 17th push, then drain with exp_valid held
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_exp(1, 'h4000 + i, 0, 0, 0, i % NC); step();
    end
    enable = 1;
    for (int i = 0; i < 20; i++) begin
      set_exp(1, 'h5000 + i, 0, 0, 0, 2); bus_follow_head(50); step();
    end
    set_exp(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) begin bus_follow_head(50); step(); end
    enable = 0; step();

    // Saturation, then clear colliding with a pass
    clear = 1; step(); clear = 0;
    enable = 1;
    for (int i = 0; i < 22; i++) begin
      set_exp(1, 'h1234, 0, 0, 0, 0); bus_follow_head(100); set_bus('h1234, 0, 0); step();
    end
    clear = 1; step(); clear = 0;
    set_exp(0, 0, 0, 0, 0, 0); step(); step();
    enable = 0; step();

    random_cycles(400);

    // Async reset with entries queued and counters non-zero
    enable = 0;
    for (int i = 0; i < 5; i++) begin set_exp(1, 'h7000 + i, 0, 0, 0, 1); step(); end
    set_exp(0, 0, 0, 0, 0, 0);
    #2 resetn = 0;
    #1;
    check("async_fifo_level", fifo_level, 0);
    check("async_exp_ready", exp_ready, 1);
    check("async_state", state, 0);
    check("async_pass_cnt", pass_cnt, 0);
    check("async_fail_cnt", fail_cnt, 0);
    check("async_starved_cnt", starved_cnt, 0);
    check("async_ff_valid", first_fail_valid, 0);
    check("async_ff_addr", first_fail_addr, 0);
    check("async_ff_cat", first_fail_cat, 0);
    step(); step();
    resetn = 1;
    enable = 1; set_bus(0, 0, 0); step();
    random_cycles(100);
    enable = 0; set_exp(0, 0, 0, 0, 0, 0); step();

    @(posedge clk); #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/proc_bus_checker.md
# proc_bus_checker

Cycle-accurate bus checker that sits beside `proc` in simulation and FPGA bring-up builds. It watches the processor's `address`/`wr_enable`/`wr_data` each clock and compares them against a queue of expected bus cycles loaded by the bench or a host. Results accumulate in per-category saturating pass/fail counters, and the first mismatch is captured. It replaces hand-written per-cycle asserts with a parametrised, reusable block.

## Interface
- `ADDR_WIDTH`, 16, processor address width
- `DATA_WIDTH`, 8, processor data width
- `DEPTH`, 16, expectation FIFO entries; power of two, ≥2
- `NUM_CAT`, 4, result categories (e.g. reset, PC, opcode, read); ≥1
- `CNT_WIDTH`, 16, width of each pass/fail counter
- `CW` (derived), max(1, ceil(log2(NUM_CAT))), category index width

Ports:
- `clk`  in  1  processor clock
- `resetn`  in  1  asynchronous, active-low reset
- `address`  in  ADDR_WIDTH  processor address
- `wr_enable`  in  1  processor write strobe
- `wr_data`  in  DATA_WIDTH  processor write data
- `enable`  in  1  comparisons active while high
- `clear`  in  1  synchronous clear of counters, first-fail capture and `starved_cnt`
- `exp_valid`  in  1  expectation push request
- `exp_ready`  out  1  FIFO can accept a push
- `exp_addr`  in  ADDR_WIDTH  expected address
- `exp_we`  in  1  expected `wr_enable`
- `exp_chk_data`  in  1  also check `wr_data` when `exp_we` = 1
- `exp_data`  in  DATA_WIDTH  expected write data
- `exp_cat`  in  CW  category index
- `pass_cnt`  out  NUM_CAT*CNT_WIDTH  packed pass counters; category k is at bits [k*CNT_WIDTH +: CNT_WIDTH]
- `fail_cnt`  out  NUM_CAT*CNT_WIDTH  packed fail counters, same packing
- `starved_cnt`  out  CNT_WIDTH  cycles in STARVED
- `first_fail_valid`  out  1  a mismatch has been captured
- `first_fail_addr`  out  ADDR_WIDTH  observed address at the first mismatch
- `first_fail_cat`  out  CW  category of the first mismatch
- `fifo_level`  out  log2(DEPTH)+1  current occupancy
- `state`  out  2  IDLE=0, RUN=1, STARVED=2

## Operation
- FIFO push occurs when `exp_valid` and `exp_ready` are both high. `exp_ready` = !full.
- Push while full is ignored, even if a pop happens in the same cycle.
- Push and pop in the same cycle on a non-full FIFO: both occur and `fifo_level` is unchanged.
- State machine:
  - IDLE → RUN when `enable` is high and the FIFO is non-empty.
  - IDLE → STARVED when `enable` is high and the FIFO is empty.
  - RUN → STARVED when `enable` is high and the FIFO is empty.
  - STARVED → RUN when `enable` is high and the FIFO is non-empty.
  - Any state → IDLE when `enable` is low.
- Each clock where `enable` is high and the FIFO is non-empty:
  - Pop the head entry.
  - Pass if `address == exp_addr` and `wr_enable == exp_we` and (!(exp_we && exp_chk_data) or `wr_data == exp_data`).
  - On pass, increment `pass_cnt[exp_cat]`. On mismatch, increment `fail_cnt[exp_cat]`.
- Each clock where `enable` is high and the FIFO is empty: increment `starved_cnt`; no compare.
- Head-of-FIFO only: an entry pushed in cycle N is first compared in cycle N+1.
- All counters saturate at all-ones and do not wrap.
- `exp_cat` ≥ NUM_CAT: the compare still pops, but no counter changes.
- First-fail capture:
  - The first mismatch after reset or `clear` loads `first_fail_addr`/`first_fail_cat` and sets `first_fail_valid`.
  - Later mismatches do not overwrite it.
- `clear`:
  - Zeroes all counters and `first_fail_valid`.
  - Leaves the FIFO and state unchanged.
  - Takes priority over an increment in the same cycle: the result is 0.
- `enable` low: the FIFO keeps its contents and nothing is popped.

## Timing
- All logic is on the `clk` rising edge, except reset.
- Reset (`resetn` low, any time, including mid-run):
  - FIFO empty; `fifo_level` 0; `exp_ready` 1; `state` IDLE.
  - All counters 0; `first_fail_valid` 0; `first_fail_addr` 0; `first_fail_cat` 0.
- Bus signals are sampled at edge E. The resulting counter and capture updates are visible immediately after E, i.e. one cycle of latency.
- Throughput: one compare per clock.
- `exp_ready` and `fifo_level` are registered and reflect pushes and pops from the previous edge.

## Test plan
- Reset vector check: push {fffc, we=0, cat0} and {fffd, we=0, cat0}; drive `address` fffc then fffd with `enable` high → `pass_cnt[0]`=2, `fail_cnt[0]`=0, `state` STARVED on the third cycle, `starved_cnt` increments.
- Mismatch capture: push {8000, cat1} and {8001, cat1}; drive 8000 then 8005 → `pass_cnt[1]`=1, `fail_cnt[1]`=1, `first_fail_addr`=8005, `first_fail_cat`=1. A further mismatch on 9000 leaves the capture at 8005.
- Write-data check: push {0200, we=1, chk=1, data=A5, cat3}; drive write of 5A to 0200 → `fail_cnt[3]`=1. Repeat with A5 → `pass_cnt[3]`=1. With chk=0, data 5A passes.
- FIFO full/simultaneous: with `enable` low, push DEPTH=16 entries → `exp_ready`=0 and a 17th push is dropped. Raise `enable` while holding `exp_valid` → one pop per cycle, pushes accepted from the cycle after `exp_ready` returns high, `fifo_level` never exceeds 16.
- Saturation and clear: with CNT_WIDTH=4, run 20 passing cycles → `pass_cnt[0]`=F. Assert `clear` in the same cycle as a pass → 0.
- Async reset mid-run: drop `resetn` with 5 entries queued and counters non-zero → all outputs return to reset values without waiting for a clock edge, and the FIFO is empty.
